// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding and line-level constants for the
// serial frame transmitter (serial_tx and serial_tx_baud).
package serial_tx_pkg;

    // Transmitter frame state, fixed at 3 bits so the encoding is stable
    // whether or not the parity stage is built.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Line levels for the non-data parts of a frame.
    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;
    localparam logic TXD_STOP  = 1'b1;

endpackage

// File: rtl/serial_tx_baud.sv
// serial_tx_baud: bit-period timer for serial_tx. Counts 0..CLKS_PER_BIT-1
// and wraps; bit_tick marks the last clk of the current bit. clear holds the
// count at zero so a frame always starts on a fresh bit period.
module serial_tx_baud #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;

    // Baud counter: cleared while idle, wraps at the end of every bit.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clear || (cnt_r == CNT_LAST)) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign bit_tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx: single-wire serial frame transmitter. Frame = start bit (0),
// DATA_W data bits LSB first, optional odd parity bit, STOP_BITS stop bits (1).
// Optional feature macro: SERIAL_TX_PARITY_EN adds the PARITY state and an odd
// parity bit captured at accept time.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              txd,
    output logic              busy
);

    localparam int BIT_CNT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ZERO  = BIT_CNT_W'(0);

    state_e              state_r;
    state_e              state_next_s;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   shift_next_s;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [BIT_CNT_W-1:0] bit_cnt_next_s;
    logic                txd_r;
    logic                txd_next_s;
    logic                busy_r;
    logic                bit_tick_s;
    logic                baud_clear_s;
    logic                in_ready_s;
    logic                accept_s;

`ifdef SERIAL_TX_PARITY_EN
    logic parity_r;
    logic parity_next_s;

    // Odd parity: 1 when the word holds an even number of ones, so the
    // data+parity total is always odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] word);
        return ~^word;
    endfunction
`endif

    serial_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .areset_n (areset_n),
        .clear    (baud_clear_s),
        .bit_tick (bit_tick_s)
    );

    // Handshake decode: ready in IDLE and in the final clk of the last stop
    // bit, which lets a queued word follow with no idle gap.
    always_comb begin
        in_ready_s   = 1'b0;
        baud_clear_s = 1'b0;
        if (state_r == IDLE) begin
            in_ready_s   = 1'b1;
            baud_clear_s = 1'b1;
        end else if ((state_r == STOP) && bit_tick_s && (bit_cnt_r == LAST_STOP_BIT)) begin
            in_ready_s   = 1'b1;
            baud_clear_s = 1'b0;
        end else begin
            in_ready_s   = 1'b0;
            baud_clear_s = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_s;
    assign in_ready = in_ready_s;

    // State register plus frame datapath (shift register, bit counter, parity).
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= BIT_CNT_ZERO;
`ifdef SERIAL_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
`ifdef SERIAL_TX_PARITY_EN
            parity_r  <= parity_next_s;
`endif
        end
    end

    // Next-state logic: bit sequencing on baud ticks, word capture on accept.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
`ifdef SERIAL_TX_PARITY_EN
        parity_next_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                bit_cnt_next_s = BIT_CNT_ZERO;
                if (accept_s) begin
                    state_next_s = START;
                    shift_next_s = in_data;
`ifdef SERIAL_TX_PARITY_EN
                    parity_next_s = odd_parity(in_data);
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    if (bit_cnt_r == LAST_DATA_BIT) begin
                        bit_cnt_next_s = BIT_CNT_ZERO;
`ifdef SERIAL_TX_PARITY_EN
                        state_next_s   = PARITY;
`else
                        state_next_s   = STOP;
`endif
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + BIT_CNT_ONE;
                        shift_next_s   = shift_r >> 1;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    if (bit_cnt_r == LAST_STOP_BIT) begin
                        bit_cnt_next_s = BIT_CNT_ZERO;
                        if (accept_s) begin
                            state_next_s = START;
                            shift_next_s = in_data;
`ifdef SERIAL_TX_PARITY_EN
                            parity_next_s = odd_parity(in_data);
`endif
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + BIT_CNT_ONE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s   = IDLE;
                bit_cnt_next_s = BIT_CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so txd shows the start bit in the
    // cycle right after the accepting edge.
    always_comb begin
        txd_next_s = TXD_IDLE;
        case (state_next_s)
            IDLE:   txd_next_s = TXD_IDLE;
            START:  txd_next_s = TXD_START;
            DATA:   txd_next_s = shift_next_s[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: txd_next_s = parity_next_s;
`else
            PARITY: txd_next_s = TXD_STOP;
`endif
            STOP:   txd_next_s = TXD_STOP;
            default: txd_next_s = TXD_IDLE;
        endcase
    end

    // Registered line and busy outputs; reset forces the line idle at once.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            txd_r  <= TXD_IDLE;
            busy_r <= 1'b0;
        end else begin
            txd_r  <= txd_next_s;
            busy_r <= (state_next_s != IDLE);
        end
    end

    assign txd  = txd_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx. Two instances:
// u_dut1 (DATA_W=8, CLKS_PER_BIT=1, STOP_BITS=1) and
// u_dut4 (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=2), sharing clock and reset.
// Expected frames are hand-written bit vectors (bit i = txd in frame cycle i).
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL1 = 1 + 8 + P + 1;
    localparam int FL4 = 4 * (1 + 8 + P + 2);

    logic       clk = 1'b0;
    logic       areset_n;
    logic       in_valid1, in_valid4;
    logic [7:0] in_data1, in_data4;
    logic       in_ready1, in_ready4;
    logic       txd1, txd4;
    logic       busy1, busy4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .areset_n(areset_n), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .txd(txd1), .busy(busy1)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .areset_n(areset_n), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .txd(txd4), .busy(busy4)
    );

    // Offer one word to u_dut1 (idle) for exactly one edge, then scramble
    // in_data so a late capture would show up on the line.
    task automatic send1(input logic [7:0] d);
        @(negedge clk);
        in_valid1 = 1'b1;
        in_data1  = d;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_data1  = ~d;
    endtask

    task automatic test_reset();
        areset_n  = 1'b0;
        in_valid1 = 1'b0; in_data1 = 8'h00;
        in_valid4 = 1'b0; in_data4 = 8'h00;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (txd1 !== 1'b1)      begin n_err++; $display("FAIL reset_txd1 cyc %0d: got %b expected 1", i, txd1); end
            n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_ready1 cyc %0d: got %b expected 1", i, in_ready1); end
            n_vec++; if (busy1 !== 1'b0)     begin n_err++; $display("FAIL reset_busy1 cyc %0d: got %b expected 0", i, busy1); end
            n_vec++; if (txd4 !== 1'b1)      begin n_err++; $display("FAIL reset_txd4 cyc %0d: got %b expected 1", i, txd4); end
            n_vec++; if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL reset_ready4 cyc %0d: got %b expected 1", i, in_ready4); end
            n_vec++; if (busy4 !== 1'b0)     begin n_err++; $display("FAIL reset_busy4 cyc %0d: got %b expected 0", i, busy4); end
        end
    endtask

    task automatic test_single(input string tag, input logic [7:0] d,
                               input logic [23:0] exp, input int len);
        send1(d);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            n_vec++; if (txd1 !== exp[i]) begin n_err++; $display("FAIL %s_txd cyc %0d: got %b expected %b", tag, i, txd1, exp[i]); end
            n_vec++; if (busy1 !== 1'b1)  begin n_err++; $display("FAIL %s_busy cyc %0d: got %b expected 1", tag, i, busy1); end
            n_vec++; if (in_ready1 !== (i == len - 1)) begin n_err++; $display("FAIL %s_ready cyc %0d: got %b expected %b", tag, i, in_ready1, (i == len - 1)); end
        end
        @(negedge clk);
        n_vec++; if (txd1 !== 1'b1)      begin n_err++; $display("FAIL %s_idle_txd: got %b expected 1", tag, txd1); end
        n_vec++; if (busy1 !== 1'b0)     begin n_err++; $display("FAIL %s_idle_busy: got %b expected 0", tag, busy1); end
        n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL %s_idle_ready: got %b expected 1", tag, in_ready1); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp;
`ifdef SERIAL_TX_PARITY_EN
        exp = {2'b00, 11'h7E0, 11'h61E};
`else
        exp = {4'h0, 10'h3E0, 10'h21E};
`endif
        @(negedge clk);
        in_valid1 = 1'b1;
        in_data1  = 8'h0F;
        @(posedge clk);
        #1;
        in_data1 = 8'hF0;
        for (int i = 0; i < 2 * FL1; i++) begin
            @(negedge clk);
            n_vec++; if (txd1 !== exp[i]) begin n_err++; $display("FAIL b2b_txd cyc %0d: got %b expected %b", i, txd1, exp[i]); end
            n_vec++; if (busy1 !== 1'b1)  begin n_err++; $display("FAIL b2b_busy cyc %0d: got %b expected 1", i, busy1); end
            if (i == FL1 - 2) begin
                n_vec++; if (in_ready1 !== 1'b0) begin n_err++; $display("FAIL b2b_ready_early: got %b expected 0", in_ready1); end
            end
            if (i == FL1 - 1) begin
                n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_stop: got %b expected 1", in_ready1); end
                @(posedge clk);
                #1;
                in_valid1 = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++; if (txd1 !== 1'b1)  begin n_err++; $display("FAIL b2b_idle_txd: got %b expected 1", txd1); end
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy: got %b expected 0", busy1); end
    endtask

    task automatic test_slow_two_stop();
        logic [11:0] exp;
`ifdef SERIAL_TX_PARITY_EN
        exp = 12'hD00;
`else
        exp = 12'h700;
`endif
        @(negedge clk);
        in_valid4 = 1'b1;
        in_data4  = 8'h80;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_data4  = 8'h7F;
        for (int i = 0; i < FL4; i++) begin
            @(negedge clk);
            n_vec++; if (txd4 !== exp[i / 4]) begin n_err++; $display("FAIL slow_txd cyc %0d: got %b expected %b", i, txd4, exp[i / 4]); end
            n_vec++; if (busy4 !== 1'b1)      begin n_err++; $display("FAIL slow_busy cyc %0d: got %b expected 1", i, busy4); end
            n_vec++; if (in_ready4 !== (i == FL4 - 1)) begin n_err++; $display("FAIL slow_ready cyc %0d: got %b expected %b", i, in_ready4, (i == FL4 - 1)); end
        end
        @(negedge clk);
        n_vec++; if (txd4 !== 1'b1)  begin n_err++; $display("FAIL slow_idle_txd: got %b expected 1", txd4); end
        n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL slow_idle_busy: got %b expected 0", busy4); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] exp;
        send1(8'hFF);
        // frame cycles 0 (start), 1..3 (data bits 0..2): stop in bit 2
        repeat (4) @(negedge clk);
        n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy1); end
        areset_n = 1'b0;
        #1;
        n_vec++; if (txd1 !== 1'b1)      begin n_err++; $display("FAIL mid_rst_txd: got %b expected 1", txd1); end
        n_vec++; if (busy1 !== 1'b0)     begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy1); end
        n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready1); end
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (txd1 !== 1'b1)  begin n_err++; $display("FAIL mid_post_txd cyc %0d: got %b expected 1", i, txd1); end
            n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_post_busy cyc %0d: got %b expected 0", i, busy1); end
        end
`ifdef SERIAL_TX_PARITY_EN
        exp = 24'h000600;
`else
        exp = 24'h000200;
`endif
        test_single("zero", 8'h00, exp, FL1);
    endtask

    initial begin
        logic [23:0] exp_a5;
        logic [23:0] exp_01;
`ifdef SERIAL_TX_PARITY_EN
        exp_a5 = 24'h00074A;
        exp_01 = 24'h000402;
`else
        exp_a5 = 24'h00034A;
        exp_01 = 24'h000202;
`endif
        test_reset();
        test_single("a5", 8'hA5, exp_a5, FL1);
        test_single("x01", 8'h01, exp_01, FL1);
        test_back_to_back();
        test_slow_two_stop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
